// File: rtl/router_pkg.sv
// Shared router types and the neighbour/ejection direction function.
// Coordinates are zero-extended to COORD_W before comparison.
package router_pkg;

  localparam int COORD_W = 8;

  typedef enum logic [3:0] {
    DIR_NE    = 4'd0,
    DIR_NW    = 4'd1,
    DIR_SE    = 4'd2,
    DIR_SW    = 4'd3,
    DIR_N     = 4'd4,
    DIR_S     = 4'd5,
    DIR_E     = 4'd6,
    DIR_W     = 4'd7,
    DIR_LOCAL = 4'd8
  } dir_t;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic [0:0] {
    ROUTE_DIAG = 1'b0,
    ROUTE_XY   = 1'b1
  } route_mode_t;

  function automatic dir_t route_calc(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] self_x,
    input logic [COORD_W-1:0] self_y,
    input route_mode_t        mode
  );
    logic gx;
    logic gy;
    logic wx;
    logic sy;
    dir_t dir;
    gx  = (dst_x != self_x);
    gy  = (dst_y != self_y);
    wx  = (dst_x < self_x);
    sy  = (dst_y < self_y);
    dir = DIR_LOCAL;
    case (mode)
      ROUTE_DIAG: begin
        if (gx && gy) begin
          // Diagonal code equals {sy, wx} by construction of dir_t.
          case ({sy, wx})
            2'b00:   dir = DIR_NE;
            2'b01:   dir = DIR_NW;
            2'b10:   dir = DIR_SE;
            2'b11:   dir = DIR_SW;
            default: dir = DIR_LOCAL;
          endcase
        end else if (gy) begin
          dir = sy ? DIR_S : DIR_N;
        end else if (gx) begin
          dir = wx ? DIR_W : DIR_E;
        end else begin
          dir = DIR_LOCAL;
        end
      end
      ROUTE_XY: begin
        if (gx) begin
          dir = wx ? DIR_W : DIR_E;
        end else if (gy) begin
          dir = sy ? DIR_S : DIR_N;
        end else begin
          dir = DIR_LOCAL;
        end
      end
      default: dir = DIR_LOCAL;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/route_calc_comb.sv
// Combinational output-direction lookup for one router port, fixed to the
// router's own coordinates and routing mode.
module route_calc_comb
  import router_pkg::*;
#(
  parameter int          XW     = 2,
  parameter int          YW     = 2,
  parameter int          SELF_X = 2,
  parameter int          SELF_Y = 2,
  parameter route_mode_t MODE   = ROUTE_DIAG
) (
  input  logic [XW-1:0] i_dst_x,
  input  logic [YW-1:0] i_dst_y,
  output dir_t          o_dir
);

  localparam logic [XW-1:0] LP_SELF_X = XW'(SELF_X);
  localparam logic [YW-1:0] LP_SELF_Y = YW'(SELF_Y);

  assign o_dir = route_calc(COORD_W'(i_dst_x), COORD_W'(i_dst_y),
                            COORD_W'(LP_SELF_X), COORD_W'(LP_SELF_Y), MODE);

endmodule

// File: rtl/route_unit.sv
// Wormhole route stage: decodes head flits, locks the direction for the
// packet and forwards flits through a single output register slice.
module route_unit
  import router_pkg::*;
#(
  parameter int          XW     = 2,
  parameter int          YW     = 2,
  parameter int          SELF_X = 2,
  parameter int          SELF_Y = 2,
  parameter int          MAX_X  = 3,
  parameter int          MAX_Y  = 3,
  parameter int          FLIT_W = 16,
  parameter route_mode_t MODE   = ROUTE_DIAG
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [FLIT_W-1:0] in_flit_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [FLIT_W-1:0] out_flit_o,
  output dir_t              out_dir_o,
  output logic              err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  dir_t              r_route;
  dir_t              r_out_dir;
  logic              r_out_valid;
  logic [FLIT_W-1:0] r_out_flit;
  logic              r_err;

  flit_type_t        w_type;
  logic [XW-1:0]     w_dst_x;
  logic [YW-1:0]     w_dst_y;
  logic              w_in_range;
  dir_t              w_calc_dir;
  dir_t              w_fwd_dir;
  logic              w_fwd;
  logic              w_err;
  logic              w_latch;
  logic              w_accept;

  assign w_type     = flit_type_t'(in_flit_i[FLIT_W-1:FLIT_W-2]);
  assign w_dst_x    = in_flit_i[XW-1:0];
  assign w_dst_y    = in_flit_i[XW+YW-1:XW];
  assign w_in_range = (int'(w_dst_x) <= MAX_X) && (int'(w_dst_y) <= MAX_Y);

  route_calc_comb #(
    .XW     (XW),
    .YW     (YW),
    .SELF_X (SELF_X),
    .SELF_Y (SELF_Y),
    .MODE   (MODE)
  ) u_calc (
    .i_dst_x (w_dst_x),
    .i_dst_y (w_dst_y),
    .o_dir   (w_calc_dir)
  );

  // Classify the presented flit: forward, error, route latch, next state.
  always_comb begin
    w_fwd       = 1'b0;
    w_err       = 1'b0;
    w_latch     = 1'b0;
    w_fwd_dir   = w_calc_dir;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        case (w_type)
          FLIT_HEAD: begin
            if (w_in_range) begin
              w_fwd       = 1'b1;
              w_latch     = 1'b1;
              w_state_nxt = ST_PKT;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_DROP;
            end
          end
          FLIT_SINGLE: begin
            if (w_in_range) begin
              w_fwd = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end
          default: w_err = 1'b1;
        endcase
      end
      ST_PKT: begin
        w_fwd_dir = r_route;
        case (w_type)
          FLIT_BODY: w_fwd = 1'b1;
          FLIT_TAIL: begin
            w_fwd       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
          default: w_err = 1'b1;
        endcase
      end
      ST_DROP: begin
        if (w_type == FLIT_TAIL) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dropped flits never occupy the slice, so they are taken regardless of it.
  assign in_ready_o = !r_out_valid || out_ready_i || !w_fwd;
  assign w_accept   = in_valid_i && in_ready_o;

  // Packet state advances only on accepted flits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      r_state <= w_state_nxt;
    end
  end

  // Direction locked by the head flit for the rest of the packet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_route <= DIR_LOCAL;
    end else if (w_accept && w_latch) begin
      r_route <= w_calc_dir;
    end
  end

  // Output slice: load and drain may happen on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_dir   <= DIR_LOCAL;
    end else if (w_accept && w_fwd) begin
      r_out_valid <= 1'b1;
      r_out_flit  <= in_flit_i;
      r_out_dir   <= w_fwd_dir;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Error pulse for the cycle following the offending flit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && w_err;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_flit_o  = r_out_flit;
  assign out_dir_o   = r_out_dir;
  assign err_o       = r_err;

endmodule

// File: tb/tb_route_unit.sv
// Directed bench: a DIAG router at (2,2) and an XY router at (1,1) share one
// stimulus stream; every expected value below is hand-derived.
module tb_route_unit;
  import router_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_flit;
  logic        out_ready;

  logic        d_ready, d_valid, d_err;
  logic [15:0] d_flit;
  logic [3:0]  d_dir;
  logic        x_ready, x_valid, x_err;
  logic [15:0] x_flit;
  logic [3:0]  x_dir;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] f_a, f_b, f_c, f_d;

  route_unit #(.XW(3), .YW(3), .SELF_X(2), .SELF_Y(2), .MAX_X(3), .MAX_Y(3),
               .FLIT_W(16), .MODE(ROUTE_DIAG)) u_diag (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(d_ready),
    .in_flit_i(in_flit), .out_valid_o(d_valid), .out_ready_i(out_ready),
    .out_flit_o(d_flit), .out_dir_o(d_dir), .err_o(d_err));

  route_unit #(.XW(3), .YW(3), .SELF_X(1), .SELF_Y(1), .MAX_X(3), .MAX_Y(3),
               .FLIT_W(16), .MODE(ROUTE_XY)) u_xy (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(x_ready),
    .in_flit_i(in_flit), .out_valid_o(x_valid), .out_ready_i(out_ready),
    .out_flit_o(x_flit), .out_dir_o(x_dir), .err_o(x_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [2:0] x,
                                     input logic [2:0] y, input logic [7:0] pl);
    return {t, pl, y, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_flit   = 16'h0000;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_d_valid", 16'(d_valid), 16'd0);
    chk("rst_d_flit", d_flit, 16'h0000);
    chk("rst_d_dir", 16'(d_dir), 16'd8);
    chk("rst_d_err", 16'(d_err), 16'd0);
    chk("rst_d_ready", 16'(d_ready), 16'd1);
    chk("rst_x_dir", 16'(x_dir), 16'd8);
    rst_n = 1'b1;
    tick();

    // SINGLE to (0,3): DIAG(2,2) -> NW, XY(1,1) -> W
    f_a = mk(2'b11, 3'd0, 3'd3, 8'hA1);
    in_valid = 1'b1;
    in_flit  = f_a;
    tick();
    chk("s1_d_valid", 16'(d_valid), 16'd1);
    chk("s1_d_flit", d_flit, f_a);
    chk("s1_d_dir", 16'(d_dir), 16'd1);
    chk("s1_d_err", 16'(d_err), 16'd0);
    chk("s1_x_dir", 16'(x_dir), 16'd7);
    // SINGLE to (2,2): DIAG -> LOCAL, XY -> E
    f_b = mk(2'b11, 3'd2, 3'd2, 8'hA2);
    in_flit = f_b;
    tick();
    chk("s2_d_flit", d_flit, f_b);
    chk("s2_d_dir", 16'(d_dir), 16'd8);
    chk("s2_x_dir", 16'(x_dir), 16'd6);
    chk("s2_d_err", 16'(d_err), 16'd0);
    in_valid = 1'b0;
    tick();
    chk("s3_d_valid", 16'(d_valid), 16'd0);

    // HEAD to (3,0), 2 BODY, TAIL: DIAG -> SE, XY -> E on every flit
    f_a = mk(2'b01, 3'd3, 3'd0, 8'h10);
    f_b = mk(2'b00, 3'd0, 3'd0, 8'h11);
    f_c = mk(2'b00, 3'd1, 3'd3, 8'h12);
    f_d = mk(2'b10, 3'd2, 3'd2, 8'h13);
    in_valid = 1'b1;
    in_flit  = f_a;
    tick();
    chk("p_h_flit", x_flit, f_a);
    chk("p_h_xdir", 16'(x_dir), 16'd6);
    chk("p_h_ddir", 16'(d_dir), 16'd2);
    in_flit = f_b;
    tick();
    chk("p_b1_flit", x_flit, f_b);
    chk("p_b1_xdir", 16'(x_dir), 16'd6);
    chk("p_b1_ddir", 16'(d_dir), 16'd2);
    in_flit = f_c;
    tick();
    chk("p_b2_flit", x_flit, f_c);
    chk("p_b2_xdir", 16'(x_dir), 16'd6);
    chk("p_b2_valid", 16'(x_valid), 16'd1);
    in_flit = f_d;
    tick();
    chk("p_t_flit", x_flit, f_d);
    chk("p_t_xdir", 16'(x_dir), 16'd6);
    chk("p_t_ddir", 16'(d_dir), 16'd2);
    in_valid = 1'b0;
    tick();
    chk("p_end_valid", 16'(x_valid), 16'd0);
    chk("p_end_err", 16'(x_err), 16'd0);

    // BODY in IDLE: dropped with a one-cycle error pulse
    in_valid = 1'b1;
    in_flit  = mk(2'b00, 3'd1, 3'd1, 8'h20);
    tick();
    chk("bi_d_err", 16'(d_err), 16'd1);
    chk("bi_x_err", 16'(x_err), 16'd1);
    chk("bi_d_valid", 16'(d_valid), 16'd0);
    in_valid = 1'b0;
    tick();
    chk("bi_d_err_clr", 16'(d_err), 16'd0);

    // HEAD to (0,0) then stall: DIAG -> SW, XY -> W
    f_a = mk(2'b01, 3'd0, 3'd0, 8'h30);
    f_b = mk(2'b00, 3'd3, 3'd3, 8'h31);
    f_c = mk(2'b10, 3'd3, 3'd3, 8'h32);
    in_valid = 1'b1;
    in_flit  = f_a;
    tick();
    chk("st_h_flit", d_flit, f_a);
    chk("st_h_ddir", 16'(d_dir), 16'd3);
    chk("st_h_xdir", 16'(x_dir), 16'd7);
    out_ready = 1'b0;
    in_flit   = f_b;
    #1;
    chk("st_ready", 16'(d_ready), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_flit", d_flit, f_a);
      chk("st_hold_dir", 16'(d_dir), 16'd3);
      chk("st_hold_valid", 16'(d_valid), 16'd1);
      chk("st_hold_ready", 16'(x_ready), 16'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("st_b_flit", d_flit, f_b);
    chk("st_b_dir", 16'(d_dir), 16'd3);
    in_flit = f_c;
    tick();
    chk("st_t_flit", d_flit, f_c);
    chk("st_t_xdir", 16'(x_dir), 16'd7);
    in_valid = 1'b0;
    tick();
    chk("st_end_valid", 16'(d_valid), 16'd0);

    // Out-of-range HEAD (4,0): error, then silent drop until TAIL
    in_valid = 1'b1;
    in_flit  = mk(2'b01, 3'd4, 3'd0, 8'h40);
    tick();
    chk("or_h_err", 16'(d_err), 16'd1);
    chk("or_h_valid", 16'(d_valid), 16'd0);
    in_flit = mk(2'b00, 3'd1, 3'd1, 8'h41);
    tick();
    chk("or_b_err", 16'(d_err), 16'd0);
    chk("or_b_valid", 16'(x_valid), 16'd0);
    in_flit = mk(2'b10, 3'd1, 3'd1, 8'h42);
    tick();
    chk("or_t_err", 16'(x_err), 16'd0);
    chk("or_t_valid", 16'(d_valid), 16'd0);
    // SINGLE to (1,3): DIAG -> NW, XY -> N
    f_a = mk(2'b11, 3'd1, 3'd3, 8'h43);
    in_flit = f_a;
    tick();
    chk("or_s_flit", d_flit, f_a);
    chk("or_s_ddir", 16'(d_dir), 16'd1);
    chk("or_s_xdir", 16'(x_dir), 16'd4);
    chk("or_s_err", 16'(d_err), 16'd0);
    // Out-of-range SINGLE (y=4): error, nothing forwarded
    in_flit = mk(2'b11, 3'd0, 3'd4, 8'h44);
    tick();
    chk("os_err", 16'(d_err), 16'd1);
    chk("os_valid", 16'(d_valid), 16'd0);

    // Reset asserted mid-packet with a flit held in the slice
    f_a = mk(2'b01, 3'd3, 3'd0, 8'h50);
    in_flit = f_a;
    tick();
    chk("rp_h_valid", 16'(d_valid), 16'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rp_valid", 16'(d_valid), 16'd0);
    chk("rp_flit", d_flit, 16'h0000);
    chk("rp_dir", 16'(d_dir), 16'd8);
    chk("rp_x_valid", 16'(x_valid), 16'd0);
    chk("rp_err", 16'(d_err), 16'd0);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_flit   = mk(2'b00, 3'd1, 3'd1, 8'h51);
    tick();
    chk("rp_body_err", 16'(d_err), 16'd1);
    chk("rp_body_xerr", 16'(x_err), 16'd1);
    chk("rp_body_valid", 16'(d_valid), 16'd0);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
